// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pkg
//  Description : Shared constants, FSM state encoding and sizing helper for
//                the serial carry-select adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    // Width of one datapath slice handled by the csa per cycle.
    localparam int SLICE_W  = 4;
    // log2(SLICE_W): shift that turns a slice index into a bit offset.
    localparam int SLICE_SH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice index counter; never narrower than one bit.
    function automatic int slice_idx_w(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa.sv
`default_nettype none
// ============================================================================
//  Module      : csa
//  Description : 4-bit carry select adder. The low bit pair ripples from Cin;
//                the high bit pair is precomputed for both carries and the
//                low-pair carry picks the correct one.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;
    logic [2:0] w_hi;

    assign w_lo  = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, Cin};
    assign w_hi0 = {1'b0, A[3:2]} + {1'b0, B[3:2]};
    assign w_hi1 = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;
    assign w_hi  = w_lo[2] ? w_hi1 : w_hi0;

    assign S    = {w_hi[1:0], w_lo[1:0]};
    assign Cout = w_hi[2];

endmodule
`default_nettype wire

// File: rtl/csa_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : csa_serial_adder
//  Description : Multi-cycle WIDTH-bit adder. Operands are accepted over a
//                valid/ready handshake, then summed one 4-bit slice per cycle
//                (LSB first) through a single combinational csa with a
//                registered inter-slice carry. The result is offered over a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_serial_adder
    import csa_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             IDX_W    = slice_idx_w(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t                 r_state;
    state_t                 w_next_state;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_carry;
    logic                   r_cout;
    logic [IDX_W-1:0]       r_idx;

    logic [IDX_W+SLICE_SH-1:0] w_base;
    logic [SLICE_W-1:0]     w_a_slice;
    logic [SLICE_W-1:0]     w_b_slice;
    logic [SLICE_W-1:0]     w_s;
    logic                   w_c;
    logic                   w_last;
    logic                   w_accept;

    // Bit offset of the current slice: index times SLICE_W.
    assign w_base    = {r_idx, {SLICE_SH{1'b0}}};
    assign w_a_slice = r_a[w_base +: SLICE_W];
    assign w_b_slice = r_b[w_base +: SLICE_W];
    assign w_last    = (r_idx == LAST_IDX);
    assign w_accept  = in_valid && in_ready;

    csa u_csa (
        .A    (w_a_slice),
        .B    (w_b_slice),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs, decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one slice of sum and carry per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_base +: SLICE_W] <= w_s;
                    r_carry                  <= w_c;
                    r_idx                    <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_csa_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_serial_adder
//  Description : Directed self-checking bench for csa_serial_adder, with a
//                WIDTH=16 instance for handshake/latency/carry cases and a
//                WIDTH=4 instance swept over every input combination.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_serial_adder;

    logic        clk;
    logic        rst;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, sum16;
    logic        cin16, cout16;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, cout4;

    int checks;
    int errors;

    csa_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16)
    );

    csa_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=16 transaction: drive, accept, measure latency, check result,
    // optionally hold out_ready low for `stall` DONE cycles, then transfer.
    task automatic txn(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tcin, input logic [15:0] esum, input logic ecout,
                       input int stall, input bit drop_after);
        int lat;
        @(negedge clk);
        a16         = ta;
        b16         = tb_v;
        cin16       = tcin;
        in_valid16  = 1'b1;
        out_ready16 = (stall == 0);
        check({tag, " in_ready"}, 32'(in_ready16), 32'd1);
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid16) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " sum"}, 32'(sum16), 32'(esum));
        check({tag, " cout"}, 32'(cout16), 32'(ecout));
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            check({tag, " stall out_valid"}, 32'(out_valid16), 32'd1);
            check({tag, " stall in_ready"}, 32'(in_ready16), 32'd0);
            check({tag, " stall sum"}, 32'(sum16), 32'(esum));
            check({tag, " stall cout"}, 32'(cout16), 32'(ecout));
        end
        out_ready16 = 1'b1;
        @(posedge clk);
        if (drop_after) begin
            @(negedge clk);
            in_valid16 = 1'b0;
            check({tag, " post in_ready"}, 32'(in_ready16), 32'd1);
            check({tag, " post out_valid"}, 32'(out_valid16), 32'd0);
        end
    endtask

    initial begin
        int vcount;
        logic [4:0] e4;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        a16         = 16'h0;
        b16         = 16'h0;
        cin16       = 1'b0;
        in_valid4   = 1'b0;
        out_ready4  = 1'b0;
        a4          = 4'h0;
        b4          = 4'h0;
        cin4        = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready16", 32'(in_ready16), 32'd1);
        check("reset out_valid16", 32'(out_valid16), 32'd0);
        check("reset sum16", 32'(sum16), 32'd0);
        check("reset cout16", 32'(cout16), 32'd0);
        check("reset in_ready4", 32'(in_ready4), 32'd1);
        check("reset out_valid4", 32'(out_valid4), 32'd0);
        check("reset sum4", 32'(sum4), 32'd0);
        rst = 1'b0;

        // Basic add and carry-ripple cases.
        txn("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b1);
        txn("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b1);
        txn("ripple2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0, 1'b1);
        txn("ripple3", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b1);

        // Backpressure: six DONE cycles with out_ready low, in_valid held high.
        txn("bp",      16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 6, 1'b1);

        // Back-to-back with in_valid continuously high.
        txn("b2b0",    16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 0, 1'b0);
        txn("b2b1",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, 1'b0);
        txn("b2b2",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 0, 1'b1);

        // Leaves a nonzero sum and cout=1 so the reset check below is meaningful.
        txn("mixed",   16'hF00F, 16'h1FF0, 1'b0, 16'h0FFF, 1'b1, 0, 1'b1);

        // Reset in the second RUN cycle discards the operation.
        @(negedge clk);
        a16         = 16'h8000;
        b16         = 16'h8000;
        cin16       = 1'b0;
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        check("rstmid in_ready", 32'(in_ready16), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid in_ready", 32'(in_ready16), 32'd1);
        check("rstmid out_valid", 32'(out_valid16), 32'd0);
        check("rstmid sum", 32'(sum16), 32'd0);
        check("rstmid cout", 32'(cout16), 32'd0);
        rst    = 1'b0;
        vcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid16) vcount++;
        end
        check("rstmid no out_valid", 32'(vcount), 32'd0);

        // WIDTH=4 instance: every a, b, cin combination, one RUN cycle each.
        out_ready4 = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a4        = 4'(ia);
                    b4        = 4'(ib);
                    cin4      = ic[0];
                    in_valid4 = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    in_valid4 = 1'b0;
                    @(negedge clk);
                    e4 = 5'(ia + ib + ic);
                    check("w4 out_valid", 32'(out_valid4), 32'd1);
                    check("w4 result", 32'({cout4, sum4}), 32'(e4));
                    @(posedge clk);
                end
            end
        end
        @(negedge clk);
        check("w4 final in_ready", 32'(in_ready4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
